// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel fetch stage.
// Holds the default 640x480 timing, derived sync windows, frame size, FIFO sizing
// and the fetch FSM state type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;

  // Sync windows are half-open: [START, END)
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 20;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  // True when lo <= v < hi
  function automatic logic in_window(logic [9:0] v, int unsigned lo, int unsigned hi);
    return (v >= 10'(lo)) && (v < 10'(hi));
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO used as the pixel prefetch buffer.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata (first-word fall-through),
// flush (clears contents, wins over push/pop), full, empty, count.
// Depth must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the count unchanged
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch stage: prefetches frame-buffer pixels over a req/ack port into a
// small FIFO and emits registered rgb/hsync/vsync/blank on each pixel strobe.
// Ports:
//   clk, rst           clock, async active-high reset
//   enable             stage enable (no fetches, no pops, forced blank when low)
//   pixel_stb, row, col, pix_addr   timer strobe and counters
//   mem_req, mem_addr, mem_ack, mem_rdata   single-outstanding read port
//   rgb, hsync, vsync, blank        registered video outputs (syncs active-low)
//   underflow, addr_err             sticky status flags, cleared only by rst
// Build option: define ADDR_CHECK_EN to store each pixel's fetch address in the FIFO and
// compare it against pix_addr on every active pop; otherwise addr_err is tied low.
module vga_pixel_fetch
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pixel_stb,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  input  logic [19:0]       pix_addr,
  output logic              mem_req,
  output logic [19:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              underflow,
  output logic              addr_err
);

`ifdef ADDR_CHECK_EN
  localparam int unsigned FifoW = DATA_W + ADDR_W;
`else
  localparam int unsigned FifoW = DATA_W;
`endif
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  // Set when a flush hits an outstanding request, so its data is dropped even if the
  // ack arrives after row has returned to the active area.
  logic              stale_q, stale_d;

  logic              flush, active_px, can_fetch, drop;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FifoW-1:0]  fifo_wdata, fifo_rdata;
  logic [CntW-1:0]   fifo_count;

  logic [DATA_W-1:0] rgb_q;
  logic              hsync_q, vsync_q, blank_q, underflow_q;

  assign flush     = (row >= 10'(V_ACTIVE));
  assign active_px = (col < 10'(H_ACTIVE)) && (row < 10'(V_ACTIVE));
  assign can_fetch = enable && !flush && (fifo_count < CntW'(FIFO_DEPTH)) &&
                     (fetch_addr_q < ADDR_W'(FRAME_PIXELS));
  assign drop      = flush || stale_q;
  assign fifo_push = (state_q == REQ) && mem_ack && !drop;
  assign fifo_pop  = pixel_stb && active_px && enable && !fifo_empty;

`ifdef ADDR_CHECK_EN
  assign fifo_wdata = {mem_addr_q, mem_rdata};
`else
  assign fifo_wdata = mem_rdata;
`endif

  pixel_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch FSM next state
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    stale_d      = stale_q;
    unique case (state_q)
      IDLE: begin
        if (can_fetch) begin
          state_d    = REQ;
          mem_addr_d = fetch_addr_q;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
          stale_d = 1'b0;
          if (!drop) fetch_addr_d = fetch_addr_q + 1'b1;
        end else if (flush) begin
          stale_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) fetch_addr_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      stale_q      <= stale_d;
    end
  end

  // Decoded straight from the state flop, so async reset drops it immediately
  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_addr_q;

  // Video outputs update only on strobes and hold in between
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      blank_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else if (pixel_stb) begin
      if (!enable) begin
        rgb_q   <= '0;
        blank_q <= 1'b1;
        hsync_q <= 1'b1;
        vsync_q <= 1'b1;
      end else begin
        hsync_q <= !in_window(col, H_SYNC_START, H_SYNC_END);
        vsync_q <= !in_window(row, V_SYNC_START, V_SYNC_END);
        if (active_px) begin
          blank_q <= 1'b0;
          if (!fifo_empty) begin
            rgb_q <= fifo_rdata[DATA_W-1:0];
          end else begin
            rgb_q       <= '0;
            underflow_q <= 1'b1;
          end
        end else begin
          rgb_q   <= '0;
          blank_q <= 1'b1;
        end
      end
    end
  end

  assign rgb       = rgb_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign underflow = underflow_q;

`ifdef ADDR_CHECK_EN
  logic addr_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else if (fifo_pop && (fifo_rdata[FifoW-1 -: ADDR_W] != pix_addr)) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
`else
  logic unused_pix_addr;
  assign unused_pix_addr = ^pix_addr;
  assign addr_err        = 1'b0;
`endif

  // Single outstanding request plus the count check means a push never meets a full FIFO
  no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_vga_pixel_fetch.sv
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        pixel_stb = 1'b0;
  logic [9:0]  row = '0;
  logic [9:0]  col = '0;
  logic [19:0] pix_addr = '0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  rgb;
  logic        hsync, vsync, blank, underflow, addr_err;

  int total = 0;
  int bad   = 0;

  // Memory model controls and scoreboard
  bit          auto_ack  = 1'b0;
  bit          force_ack = 1'b0;
  int          n_acks    = 0;
  logic [7:0]  exp_q [$];
  logic [19:0] addr_q [$];

  always #5 clk = ~clk;

  vga_pixel_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pixel_stb (pixel_stb),
    .row       (row),
    .col       (col),
    .pix_addr  (pix_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .blank     (blank),
    .underflow (underflow),
    .addr_err  (addr_err)
  );

  // Zero-wait responder: answers a pending request on the falling edge so the DUT
  // sees ack on the first rising edge of its REQ state. Data landing while row is in
  // the blanking rows is expected to be dropped, so it is not scoreboarded.
  always @(negedge clk) begin
    if (auto_ack && mem_req) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'(32'hA0 + n_acks);
      addr_q.push_back(mem_addr);
      if (row < 10'(V_ACTIVE)) exp_q.push_back(mem_rdata);
      n_acks++;
    end else begin
      mem_ack = force_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int r, input int c);
    row       = 10'(r);
    col       = 10'(c);
    pix_addr  = 20'(r * 640 + c);
    pixel_stb = 1'b1;
    tick();
    pixel_stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] got, want;
    int k;
    rst = 1'b1;
    tick();
    tick();
    got  = {mem_req, mem_addr, rgb, hsync, vsync, blank, underflow, addr_err};
    want = {1'b0, 20'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_values: got %h want %h", got, want);
    end
    // Bring up a request and reset in the middle of it
    rst    = 1'b0;
    enable = 1'b1;
    row    = '0;
    k = 0;
    while (!mem_req && k < 10) begin
      tick();
      k++;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 20'd0) begin
      bad++;
      $display("FAIL reset_req_up: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_req: got %b want 0", mem_req);
    end
    enable = 1'b0;
    tick();
    rst       = 1'b0;
    force_ack = 1'b1;
    tick();
    tick();
    force_ack = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_late_ack: got req=%b want 0", mem_req);
    end
    exp_q.delete();
    addr_q.delete();
    n_acks = 0;
  endtask

  task automatic test_fill();
    enable   = 1'b1;
    row      = '0;
    col      = '0;
    auto_ack = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 20'd0) begin
      bad++;
      $display("FAIL fill_first_req: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr);
    end
    repeat (7) tick();
    total++;
    if (n_acks != 4 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fill_timing: got acks=%0d req=%b want acks=4 req=0", n_acks, mem_req);
    end
    repeat (10) tick();
    total++;
    if (n_acks != 4 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fill_stop: got acks=%0d req=%b want acks=4 req=0", n_acks, mem_req);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= addr_q.size() || addr_q[i] !== 20'(i)) begin
        bad++;
        $display("FAIL fill_addr%0d: got %0d want %0d", i,
                 (i < addr_q.size()) ? addr_q[i] : 20'hFFFFF, i);
      end
    end
  endtask

  task automatic test_pixel_out();
    logic [7:0] exp;
    int k;
    strobe(0, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (rgb !== 8'hA0 || rgb !== exp || blank !== 1'b0) begin
      bad++;
      $display("FAIL pixel_first: got rgb=%h blank=%b want rgb=a0 blank=0", rgb, blank);
    end
    k = 0;
    while (!mem_req && k < 10) begin
      tick();
      k++;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 20'd4) begin
      bad++;
      $display("FAIL pixel_refill: got req=%b addr=%0d want req=1 addr=4", mem_req, mem_addr);
    end
    repeat (4) tick();
    total++;
    if (rgb !== exp || blank !== 1'b0) begin
      bad++;
      $display("FAIL pixel_hold: got rgb=%h blank=%b want rgb=%h blank=0", rgb, blank, exp);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] exp;
    logic       exp_uf;
    auto_ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      strobe(0, i);
      exp    = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      exp_uf = (i == 5);
      total++;
      if (rgb !== exp || blank !== 1'b0 || underflow !== exp_uf) begin
        bad++;
        $display("FAIL underflow_px%0d: got rgb=%h blank=%b uf=%b want rgb=%h blank=0 uf=%b",
                 i, rgb, blank, underflow, exp, exp_uf);
      end
      tick();
    end
    auto_ack = 1'b1;
    repeat (12) tick();
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL underflow_sticky: got %b want 1", underflow);
    end
    strobe(0, 5);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (rgb !== 8'hA5 || rgb !== exp || blank !== 1'b0) begin
      bad++;
      $display("FAIL underflow_resume: got rgb=%h blank=%b want rgb=a5 blank=0", rgb, blank);
    end
  endtask

  task automatic test_syncs();
    int         hcols [5] = '{655, 656, 751, 752, 640};
    logic [4:0] hwant = 5'b10011;
    int         vrows [4] = '{489, 490, 491, 492};
    logic [3:0] vwant = 4'b1001;
    repeat (4) tick();
    auto_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      strobe(0, hcols[i]);
      total++;
      if (hsync !== hwant[4-i] || blank !== 1'b1 || rgb !== 8'h00) begin
        bad++;
        $display("FAIL hsync_col%0d: got hs=%b blank=%b rgb=%h want hs=%b blank=1 rgb=00",
                 hcols[i], hsync, blank, rgb, hwant[4-i]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      strobe(vrows[i], 0);
      total++;
      if (vsync !== vwant[3-i] || hsync !== 1'b1 || blank !== 1'b1) begin
        bad++;
        $display("FAIL vsync_row%0d: got vs=%b hs=%b blank=%b want vs=%b hs=1 blank=1",
                 vrows[i], vsync, hsync, blank, vwant[3-i]);
      end
      tick();
    end
    exp_q.delete();
    enable = 1'b0;
    strobe(490, 700);
    total++;
    if ({hsync, vsync, blank, rgb} !== {3'b111, 8'h00}) begin
      bad++;
      $display("FAIL disabled_syncs: got hs=%b vs=%b blank=%b rgb=%h want 1 1 1 00",
               hsync, vsync, blank, rgb);
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    int k;
    auto_ack = 1'b1;
    row      = '0;
    repeat (12) tick();
    auto_ack = 1'b0;
    strobe(0, 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (rgb !== exp || blank !== 1'b0) begin
      bad++;
      $display("FAIL flush_prefill: got rgb=%h blank=%b want rgb=%h blank=0", rgb, blank, exp);
    end
    k = 0;
    while (!mem_req && k < 10) begin
      tick();
      k++;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 20'd4) begin
      bad++;
      $display("FAIL flush_pending: got req=%b addr=%0d want req=1 addr=4", mem_req, mem_addr);
    end
    row      = 10'd480;
    auto_ack = 1'b1;
    exp_q.delete();
    repeat (4) tick();
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_no_req: got %b want 0", mem_req);
    end
    auto_ack = 1'b0;
    row      = '0;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 20'd0) begin
      bad++;
      $display("FAIL flush_restart: got req=%b addr=%0d want req=1 addr=0", mem_req, mem_addr);
    end
    strobe(0, 0);
    total++;
    if (rgb !== 8'h00 || blank !== 1'b0) begin
      bad++;
      $display("FAIL flush_empty: got rgb=%h blank=%b want rgb=00 blank=0", rgb, blank);
    end
    tick();
  endtask

  task automatic test_addr_check();
    logic [7:0] exp;
    logic       exp_err;
    auto_ack = 1'b1;
    repeat (12) tick();
    for (int c = 0; c < 6; c++) begin
      strobe(0, c);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      total++;
      if (rgb !== exp || blank !== 1'b0 || addr_err !== 1'b0) begin
        bad++;
        $display("FAIL addr_match_col%0d: got rgb=%h blank=%b err=%b want rgb=%h blank=0 err=0",
                 c, rgb, blank, addr_err, exp);
      end
      tick();
      tick();
    end
`ifdef ADDR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    // Head entry holds address 6 while the timer claims pixel 7
    strobe(0, 7);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (rgb !== exp || addr_err !== exp_err) begin
      bad++;
      $display("FAIL addr_mismatch: got rgb=%h err=%b want rgb=%h err=%b",
               rgb, addr_err, exp, exp_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pixel_out();
    test_underflow();
    test_syncs();
    test_flush();
    test_addr_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
